// File: rtl/led_sequencer_pkg.sv
// led_sequencer_pkg: shared types and the pattern step function for the LED sequencer
//   led_mode_t   : OFF / COUNT / WALK / HOLD pattern modes
//   seq_state_t  : bus FSM states IDLE / WRITE
//   rgb_led_t    : packed 8-bit-per-channel RGB value
//   next_pattern : pattern produced by one processed tick
package led_sequencer_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        COUNT = 2'd1,
        WALK  = 2'd2,
        HOLD  = 2'd3
    } led_mode_t;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } seq_state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_led_t;

    function automatic logic [7:0] next_pattern(led_mode_t mode, logic [7:0] p, logic [7:0] user);
        logic one_hot;
        one_hot = (p != 8'd0) && ((p & (p - 8'd1)) == 8'd0);
        return mode == OFF   ? 8'h00 :
               mode == COUNT ? p + 8'd1 :
               mode == WALK  ? (one_hot ? {p[6:0], p[7]} : 8'h01) :
                               user;
    endfunction

endpackage

// File: rtl/led_sequencer_tick_divider.sv
// tick_divider: one-cycle tick every DIV enabled clock cycles
//   clk_i  : system clock
//   rst_i  : asynchronous active-high reset
//   enable : 1 = count, 0 = counter held at 0
//   tick   : registered pulse, first one DIV cycles after counting starts
module tick_divider #(
    parameter int DIV = 12000000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic enable,
    output logic tick
);

    localparam int W = $clog2(DIV);

    logic [W-1:0] cnt;
    logic         wrap;

    assign wrap = cnt == W'(DIV - 1);

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= (!enable || wrap) ? '0 : cnt + 1'b1;
            tick <= enable && wrap;
        end

endmodule

// File: rtl/led_sequencer.sv
// led_sequencer: steps an 8-bit LED pattern on a divided tick and writes it over Wishbone
//   clk_i, rst_i       : clock, asynchronous active-high reset
//   enable             : run the tick divider
//   mode, user_pattern : pattern mode and HOLD value, sampled when a tick is processed
//   err_clr            : clears the sticky timeout flag
//   cyc_o/stb_o/we_o, adr_o, dat_o, ack_i : Wishbone classic controller write port
//   pattern, busy, err : committed pattern, WRITE in progress, bus timeout flag
// Optional: define LED_SEQUENCER_TIMEOUT_EN to abort a write after 16 unacknowledged cycles.
module led_sequencer
    import led_sequencer_pkg::*;
#(
    parameter int          TICK_DIV = 12000000,
    parameter logic [31:0] LED_ADDR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable,
    input  logic [1:0]  mode,
    input  logic [7:0]  user_pattern,
    input  logic        err_clr,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [31:0] adr_o,
    output logic [31:0] dat_o,
    input  logic        ack_i,
    output logic [7:0]  pattern,
    output logic        busy,
    output logic        err
);

    seq_state_t state, state_n;
    logic       tick, pending, proc, tmo;
    logic [7:0] nxt;

    tick_divider #(.DIV(TICK_DIV)) u_tick (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .enable (enable),
        .tick   (tick)
    );

    // a tick seen during WRITE is replayed in the first IDLE cycle
    assign proc = state == IDLE && (tick || pending);
    assign nxt  = next_pattern(led_mode_t'(mode), pattern, user_pattern);

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            state   <= IDLE;
            pattern <= 8'h00;
            pending <= 1'b0;
        end else begin
            state   <= state_n;
            pattern <= proc ? nxt : pattern;
            pending <= enable && state == WRITE && (pending || tick);
        end

    always_comb begin
        state_n = state;
        state_n = state == IDLE ? ((proc && nxt != pattern) ? WRITE : IDLE) :
                                  ((ack_i || tmo) ? IDLE : WRITE);
    end

    always_comb begin
        cyc_o = state == WRITE;
        stb_o = state == WRITE;
        we_o  = state == WRITE;
        busy  = state == WRITE;
    end

    assign adr_o = LED_ADDR;
    assign dat_o = {24'b0, pattern};

`ifdef LED_SEQUENCER_TIMEOUT_EN
    logic [3:0] tcnt;

    // 16th consecutive unacknowledged WRITE cycle aborts the transfer
    assign tmo = state == WRITE && !ack_i && tcnt == 4'd15;

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            tcnt <= 4'd0;
            err  <= 1'b0;
        end else begin
            tcnt <= (state == WRITE && !ack_i) ? tcnt + 4'd1 : 4'd0;
            err  <= tmo ? 1'b1 : err_clr ? 1'b0 : err;
        end
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign tmo = 1'b0;
    assign err = 1'b0;
`endif

`ifdef FORMAL
    a_idle_quiet: assert property (@(posedge clk_i) disable iff (rst_i)
        state == IDLE |-> !cyc_o && !stb_o && !we_o);
    c_round_trip: cover property (@(posedge clk_i) disable iff (rst_i)
        state == IDLE ##1 state == WRITE ##[1:$] state == IDLE);
`endif

endmodule
